// File: rtl/adder_result_stage_if.sv
// Stream bundle for adder_result_stage: adder beat in, registered beat out, carry counter.
// ADDER_RESULT_OVF_EN adds operand sign bits on the input side and out_ovf on the output side.
// Signals only; no state. Master is the driving source/sink, slave is the stage.
interface adder_result_stage_if #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
);
  logic [DATA_WIDTH-1:0] sum_i;
  logic                  co_i;
  logic                  in_vld;
  logic                  in_rd;
  logic [DATA_WIDTH-1:0] out_sum;
  logic                  out_co;
  logic                  out_vld;
  logic                  out_rd;
  logic                  cnt_clr;
  logic [CNT_WIDTH-1:0]  carry_cnt;
`ifdef ADDER_RESULT_OVF_EN
  logic                  a_msb_i;
  logic                  b_msb_i;
  logic                  out_ovf;

  modport master (
    output sum_i, co_i, in_vld, out_rd, cnt_clr, a_msb_i, b_msb_i,
    input  in_rd, out_sum, out_co, out_vld, carry_cnt, out_ovf
  );
  modport slave (
    input  sum_i, co_i, in_vld, out_rd, cnt_clr, a_msb_i, b_msb_i,
    output in_rd, out_sum, out_co, out_vld, carry_cnt, out_ovf
  );
`else
  modport master (
    output sum_i, co_i, in_vld, out_rd, cnt_clr,
    input  in_rd, out_sum, out_co, out_vld, carry_cnt
  );
  modport slave (
    input  sum_i, co_i, in_vld, out_rd, cnt_clr,
    output in_rd, out_sum, out_co, out_vld, carry_cnt
  );
`endif
endinterface

// File: rtl/adder_result_stage.sv
// Registered 2-entry skid stage behind the ripple adder, plus saturating carry-out counter (opt. ADDER_RESULT_OVF_EN).
// Latency: 1 cycle when main is empty or drained the same cycle, otherwise queued behind the older beat.
// Backpressure: in_rd = !skid_vld from a register, so out_rd never reaches the adder side combinationally.
module adder_result_stage #(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_result_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] sum;
    logic                  co;
`ifdef ADDER_RESULT_OVF_EN
    logic                  ovf;
`endif
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t               state;
  beat_t                main_q;
  beat_t                skid_q;
  beat_t                in_beat;
  logic                 in_rd_q;
  logic                 out_vld_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 accept;
  logic                 consume;

  always_comb begin
    in_beat     = '0;
    in_beat.sum = bus.sum_i;
    in_beat.co  = bus.co_i;
`ifdef ADDER_RESULT_OVF_EN
    // Signed overflow: same operand signs, result sign differs.
    in_beat.ovf = (bus.a_msb_i == bus.b_msb_i) && (bus.sum_i[DATA_WIDTH-1] != bus.a_msb_i);
`endif
  end

  assign accept  = bus.in_vld & in_rd_q;
  assign consume = out_vld_q & bus.out_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_rd_q   <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= in_beat;
            out_vld_q <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_q <= in_beat;
          end else if (accept) begin
            skid_q  <= in_beat;
            in_rd_q <= 1'b0;
            state   <= FULL;
          end else if (consume) begin
            out_vld_q <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            main_q  <= skid_q;
            skid_q  <= '0;
            in_rd_q <= 1'b1;
            state   <= ONE;
          end
        end
        default: begin
          out_vld_q <= 1'b0;
          in_rd_q   <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

  // Clear wins over a same-cycle increment; saturates at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (accept && bus.co_i && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.in_rd     = in_rd_q;
  assign bus.out_vld   = out_vld_q;
  assign bus.out_sum   = main_q.sum;
  assign bus.out_co    = main_q.co;
  assign bus.carry_cnt = cnt_q;
`ifdef ADDER_RESULT_OVF_EN
  assign bus.out_ovf   = main_q.ovf;
`endif

endmodule
